// File: rtl/shift_issue_ctrl32_if.sv
// Bundle of the request handshake, shifter drive/return lines and result
// handshake of the shift issue controller. The slave modport is the
// controller's view; the master modport is the view of whatever surrounds it
// (request source, gate-level shifters and writeback consumer).
interface shift_issue_ctrl32_if;
  logic        Req_Valid;
  logic        Req_Ready;
  logic [1:0]  Req_Op;
  logic [31:0] Req_A;
  logic [4:0]  Req_Shamt;
  logic [31:0] Sh_In1;
  logic [31:0] Sh_In2;
  logic        Sh_LEn;
  logic        Sh_REn;
  logic        Sh_Arith;
  logic [31:0] Sh_LOut;
  logic [31:0] Sh_ROut;
  logic        Res_Valid;
  logic        Res_Ready;
  logic [31:0] Res_Data;
  logic        Res_Err;
  logic        Busy;

  modport slave (
    input  Req_Valid, Req_Op, Req_A, Req_Shamt, Sh_LOut, Sh_ROut, Res_Ready,
    output Req_Ready, Sh_In1, Sh_In2, Sh_LEn, Sh_REn, Sh_Arith,
           Res_Valid, Res_Data, Res_Err, Busy
  );

  modport master (
    output Req_Valid, Req_Op, Req_A, Req_Shamt, Sh_LOut, Sh_ROut, Res_Ready,
    input  Req_Ready, Sh_In1, Sh_In2, Sh_LEn, Sh_REn, Sh_Arith,
           Res_Valid, Res_Data, Res_Err, Busy
  );
endinterface

// File: rtl/shift_issue_ctrl32.sv
// Shift issue controller: registers a shift request, holds the operands on
// the external 32-bit shifters with the proper enable for SETTLE_CYCLES
// cycles, captures the selected shifter output and holds it until the
// writeback consumer takes it. Reserved opcodes complete immediately with an
// error flag and never enable a shifter.
module shift_issue_ctrl32 #(
  parameter int SETTLE_CYCLES = 1
) (
  input logic                  Clk,
  input logic                  Rst_n,
  shift_issue_ctrl32_if.slave  bus
);

  localparam int DATA_W = 32;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  // Settle window must fit the 4-bit counter and be at least one cycle.
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("shift_issue_ctrl32: SETTLE_CYCLES=%0d outside 1..15", SETTLE_CYCLES);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_op;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic              r_len;
  logic              r_ren;
  logic              r_arith;
  logic [DATA_W-1:0] r_res_data;
  logic              r_res_err;

  // Issue FSM: accept in IDLE, hold shifter enables through EXEC, present the
  // captured result in DONE until the consumer takes it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_SLL;
      r_cnt      <= 4'd0;
      r_in1      <= '0;
      r_in2      <= '0;
      r_len      <= 1'b0;
      r_ren      <= 1'b0;
      r_arith    <= 1'b0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Req_Valid) begin
            r_in1 <= bus.Req_A;
            r_in2 <= {27'b0, bus.Req_Shamt};
            r_op  <= bus.Req_Op;
            r_cnt <= CNT_INIT;
            if (bus.Req_Op == OP_RSV) begin
              // Reserved op: finish at once with a zero result and the error flag.
              r_res_data <= '0;
              r_res_err  <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_len   <= (bus.Req_Op == OP_SLL);
              r_ren   <= (bus.Req_Op == OP_SRL) || (bus.Req_Op == OP_SRA);
              r_arith <= (bus.Req_Op == OP_SRA);
              r_state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // Settle window over: sample whichever shifter was enabled.
            r_res_data <= (r_op == OP_SLL) ? bus.Sh_LOut : bus.Sh_ROut;
            r_res_err  <= 1'b0;
            r_len      <= 1'b0;
            r_ren      <= 1'b0;
            r_arith    <= 1'b0;
            r_state    <= DONE;
          end
        end
        DONE: begin
          // New requests wait for IDLE even if one is offered while the result drains.
          if (bus.Res_Ready) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Req_Ready = (r_state == IDLE);
  assign bus.Res_Valid = (r_state == DONE);
  assign bus.Busy      = (r_state != IDLE);
  assign bus.Sh_In1    = r_in1;
  assign bus.Sh_In2    = r_in2;
  assign bus.Sh_LEn    = r_len;
  assign bus.Sh_REn    = r_ren;
  assign bus.Sh_Arith  = r_arith;
  assign bus.Res_Data  = r_res_data;
  assign bus.Res_Err   = r_res_err;

endmodule
